dec_buf: RTL and testbench

DEC_BUF -- requirements
Module: dec_buf

---
 rtl/dec_buf_pkg.sv | 17 +
 rtl/dec_buf_mem.sv | 30 +++
 rtl/dec_buf.sv | 113 +++++++++++
 tb/tb_dec_buf.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/dec_buf_pkg.sv
// Shared core package: pipeline-wide constants and the decode-buffer
// state encoding.
//   XLEN_DEF  default datapath width (PC, next-PC, instruction)
//   NOP_INST  canonical bubble, add x0,x0,x0
//   dbuf_st_e decode-buffer sequencing states
package dec_buf_pkg;

    localparam int          XLEN_DEF  = 32;
    localparam logic [31:0] NOP_INST  = 32'h0000_0033;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    typedef enum logic {
        ST_WAIT = 1'b0,   // one settling cycle after reset, no traffic
        ST_RUN  = 1'b1    // normal push/pop operation
    } dbuf_st_e;

endpackage

// File: rtl/dec_buf_mem.sv
// Decode-buffer storage: DEPTH x W register array, one synchronous
// write port and one asynchronous read port. Contents are not reset.
//   i_clk    clock
//   i_we     write enable
//   i_waddr  write index
//   i_wdata  write data
//   i_raddr  read index
//   o_rdata  read data (combinational)
module dec_buf_mem #(
    parameter int W     = 96,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) mem_q[i_waddr] <= i_wdata;
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/dec_buf.sv
// Decode buffer: small FWFT queue between fetch and decode. Holds
// {inst, pc, nxt_pc} entries; presents a NOP bubble when empty.
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_vld/i_inst/i_pc/i_nxt_pc  fetch offer; accepted when o_rdy
//   o_rdy               buffer can accept a push this cycle
//   i_flush             redirect: drop all entries and any same-cycle push
//   i_hold              decode stall: head is not consumed
//   o_vld/o_inst/o_pc/o_nxt_pc  head entry (NOP / 0 when not valid)
//   o_count, o_full, o_empty    occupancy status
module dec_buf
    import dec_buf_pkg::*;
#(
    parameter int              XLEN  = XLEN_DEF,
    parameter int              DEPTH = 4,
    parameter logic [XLEN-1:0] NOP   = XLEN'(NOP_INST),
    parameter int              CW    = $clog2(DEPTH + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_vld,
    input  logic [XLEN-1:0] i_inst,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_nxt_pc,
    output logic            o_rdy,
    input  logic            i_flush,
    input  logic            i_hold,
    output logic            o_vld,
    output logic [XLEN-1:0] o_inst,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_nxt_pc,
    output logic [CW-1:0]   o_count,
    output logic            o_full,
    output logic            o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = 3 * XLEN;

    dbuf_st_e      state_q, state_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          run;
    logic          push, pop;
    logic [EW-1:0] rd_ent;

    assign run     = (state_q == ST_RUN);
    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;

    // o_rdy looks only at current occupancy: a full buffer stays closed
    // even when the head pops in the same cycle.
    assign o_rdy = run && !o_full && !i_flush;
    assign o_vld = run && !o_empty;
    assign push  = i_vld && o_rdy;
    assign pop   = o_vld && !i_hold && !i_flush;

    dec_buf_mem #(.W(EW), .DEPTH(DEPTH), .AW(PW)) u_mem (
        .i_clk   (i_clk),
        .i_we    (push),
        .i_waddr (tail_q),
        .i_wdata ({i_inst, i_pc, i_nxt_pc}),
        .i_raddr (head_q),
        .o_rdata (rd_ent)
    );

    assign o_inst   = o_vld ? rd_ent[3*XLEN-1:2*XLEN] : NOP;
    assign o_pc     = o_vld ? rd_ent[2*XLEN-1:XLEN]   : '0;
    assign o_nxt_pc = o_vld ? rd_ent[XLEN-1:0]        : '0;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        unique case (state_q)
            ST_WAIT: state_d = ST_RUN;
            ST_RUN: begin
                if (i_flush) begin
                    head_d  = '0;
                    tail_d  = '0;
                    count_d = '0;
                end else begin
                    if (push) tail_d = tail_q + PW'(1);
                    if (pop)  head_d = head_q + PW'(1);
                    unique case ({push, pop})
                        2'b10:   count_d = count_q + CW'(1);
                        2'b01:   count_d = count_q - CW'(1);
                        default: count_d = count_q;
                    endcase
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_WAIT;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_dec_buf.sv
module tb_dec_buf;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0033;

    logic        clk = 1'b0;
    logic        i_rst, i_vld, i_flush, i_hold;
    logic [31:0] i_inst, i_pc, i_nxt_pc;
    logic        o_rdy, o_vld, o_full, o_empty;
    logic [31:0] o_inst, o_pc, o_nxt_pc;
    logic [2:0]  o_count;

    always #5 clk = ~clk;

    dec_buf dut (
        .i_clk(clk), .i_rst(i_rst), .i_vld(i_vld), .i_inst(i_inst),
        .i_pc(i_pc), .i_nxt_pc(i_nxt_pc), .o_rdy(o_rdy), .i_flush(i_flush),
        .i_hold(i_hold), .o_vld(o_vld), .o_inst(o_inst), .o_pc(o_pc),
        .o_nxt_pc(o_nxt_pc), .o_count(o_count), .o_full(o_full),
        .o_empty(o_empty)
    );

    // Reference model: a plain queue of entries plus a "running" flag.
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
    } ent_t;

    ent_t q[$];
    bit   m_run   = 0;
    bit   m_known = 0;
    int   checks  = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle: apply inputs, check outputs against the model,
    // advance the model by the same rules, then cross the clock edge.
    task automatic cyc(input string tag, input logic rst, input logic vld,
                       input logic flush, input logic hold,
                       input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] npc);
        bit e_rdy, e_vld, e_push, e_pop;
        ent_t e;
        i_rst = rst; i_vld = vld; i_flush = flush; i_hold = hold;
        i_inst = inst; i_pc = pc; i_nxt_pc = npc;
        #1;
        e_rdy = m_run && (q.size() < DEPTH) && !flush;
        e_vld = m_run && (q.size() > 0);
        if (m_known) begin
            chk({tag, ":rdy"},   32'(o_rdy),   32'(e_rdy));
            chk({tag, ":vld"},   32'(o_vld),   32'(e_vld));
            chk({tag, ":inst"},  o_inst,       e_vld ? q[0].inst : NOP);
            chk({tag, ":pc"},    o_pc,         e_vld ? q[0].pc   : 32'h0);
            chk({tag, ":npc"},   o_nxt_pc,     e_vld ? q[0].npc  : 32'h0);
            chk({tag, ":count"}, 32'(o_count), 32'(q.size()));
            chk({tag, ":full"},  32'(o_full),  32'(q.size() == DEPTH));
            chk({tag, ":empty"}, 32'(o_empty), 32'(q.size() == 0));
        end
        e_push = vld && e_rdy;
        e_pop  = e_vld && !hold && !flush;
        if (rst) begin
            q.delete(); m_run = 0; m_known = 1;
        end else if (m_known) begin
            if (!m_run) m_run = 1;
            else if (flush) q.delete();
            else begin
                if (e_pop) void'(q.pop_front());
                if (e_push) begin
                    e.inst = inst; e.pc = pc; e.npc = npc;
                    q.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic hold);
        cyc(tag, 0, 0, 0, hold, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic push(input string tag, input logic hold, input logic [31:0] inst,
                        input logic [31:0] pc);
        cyc(tag, 0, 1, 0, hold, inst, pc, pc + 32'h4);
    endtask

    logic [31:0] fill_inst [4];

    initial begin
        fill_inst[0] = 32'h0010_0093; fill_inst[1] = 32'h0020_0113;
        fill_inst[2] = 32'h0030_0193; fill_inst[3] = 32'h0040_0213;

        // Reset then idle
        cyc("rst", 1, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        chk("wait_rdy",  32'(o_rdy), 32'h0);
        chk("wait_inst", o_inst, NOP);
        idle("wait", 0);
        chk("run_rdy",   32'(o_rdy), 32'h1);
        chk("run_empty", 32'(o_empty), 32'h1);
        idle("run", 0);

        // Fill under hold, then offer a fifth entry that must be dropped
        for (int i = 0; i < 4; i++) push("fill", 1, fill_inst[i], 32'(i * 4));
        chk("fill_full",  32'(o_full), 32'h1);
        chk("fill_count", 32'(o_count), 32'h4);
        chk("fill_rdy",   32'(o_rdy), 32'h0);
        push("drop5", 1, 32'h0050_0293, 32'h10);
        idle("hold", 1);

        // Drain in order
        for (int i = 0; i < 4; i++) begin
            chk("drain_inst", o_inst, fill_inst[i]);
            idle("drain", 0);
        end
        chk("drained_vld",  32'(o_vld), 32'h0);
        chk("drained_inst", o_inst, NOP);

        // Simultaneous push/pop at count 2, wrapping the pointers
        push("pp_pre", 1, 32'h1000_0013, 32'h100);
        push("pp_pre", 1, 32'h1000_1013, 32'h104);
        for (int i = 0; i < 10; i++) begin
            push("pp", 0, 32'h2000_0013 + 32'(i), 32'h200 + 32'(i * 4));
            chk("pp_count", 32'(o_count), 32'h2);
        end
        idle("pp_drain", 0);
        idle("pp_drain", 0);
        idle("pp_drain", 0);

        // Flush with a same-cycle push at count 3
        for (int i = 0; i < 3; i++) push("fl_pre", 1, 32'h3000_0013 + 32'(i), 32'h300 + 32'(i * 4));
        cyc("flush", 0, 1, 1, 0, 32'hDEAD_0013, 32'h3FC, 32'h400);
        chk("flush_count", 32'(o_count), 32'h0);
        chk("flush_vld",   32'(o_vld), 32'h0);
        idle("post_flush", 0);

        // Reset at count 3 mid-drain
        for (int i = 0; i < 4; i++) push("rs_pre", 1, 32'h4000_0013 + 32'(i), 32'h500 + 32'(i * 4));
        idle("rs_drain1", 0);
        chk("rs_count3", 32'(o_count), 32'h3);
        cyc("rst_mid", 1, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        chk("rs_inst",  o_inst, NOP);
        chk("rs_empty", 32'(o_empty), 32'h1);
        push("rs_wait_push", 0, 32'hBAD0_0013, 32'h6FC);
        push("rs_push", 0, 32'h5000_0013, 32'h700);
        chk("rs_pop_pc", o_pc, 32'h700);
        idle("rs_pop", 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc("rand", ($urandom_range(99) == 0), ($urandom_range(9) < 7),
                ($urandom_range(19) == 0), ($urandom_range(9) < 3),
                $urandom, $urandom, $urandom);
        end
        for (int i = 0; i < 6; i++) idle("final", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
